// File: rtl/frame_uart_sequencer.sv
// Streams one buffered frame out over a byte-wide UART: a two-byte sync header,
// then every 32-bit buffer word MSB first, with a holdoff gap between bytes.
module frame_uart_sequencer #(
    parameter int          COLS         = 40,
    parameter int          ROWS         = 30,
    parameter int          HOLDOFF_BITS = 13,
    parameter logic [7:0]  SYNC0        = 8'hFF,
    parameter logic [7:0]  SYNC1        = 8'h00
) (
    input  logic        clk12,
    input  logic        areset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        frame_done,
    output logic [5:0]  read_x,
    output logic [4:0]  read_y,
    input  logic [31:0] read_q,
    input  logic        uart_busy,
    output logic        uart_wr,
    output logic [7:0]  uart_dat,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, WAIT_FRAME, HEADER, FETCH, LATCH, SEND, DONE
    } state_e;

    localparam logic [5:0] X_LAST = 6'(COLS - 1);
    localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

    state_e                  state_q, state_d;
    logic [5:0]              x_q, x_d;
    logic [4:0]              y_q, y_d;
    logic [1:0]              idx_q, idx_d;
    logic [31:0]             word_q, word_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic                    wr_q, wr_d;
    logic [7:0]              dat_q, dat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic can_send, kill, more_words;

    assign can_send   = (&hold_q) && !uart_busy && !wr_q;
    assign kill       = abort && (state_q != IDLE);
    assign more_words = (x_q < X_LAST) || (y_q < Y_LAST);

    always_ff @(posedge clk12 or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            hold_q  <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            hold_q  <= hold_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = WAIT_FRAME;
            WAIT_FRAME: if (frame_done) state_d = HEADER;
            HEADER:     if (can_send && idx_q == 2'd1) state_d = FETCH;
            FETCH:      state_d = LATCH;
            LATCH:      state_d = SEND;
            SEND:       if (can_send && idx_q == 2'd3) state_d = more_words ? FETCH : DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        idx_d  = idx_q;
        word_d = word_q;
        wr_d   = 1'b0;
        dat_d  = dat_q;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        // Gap counter restarts on every strobe and while the UART is busy.
        hold_d = hold_q;
        if (uart_busy || wr_q) hold_d = '0;
        else if (!(&hold_q))   hold_d = hold_q + HOLDOFF_BITS'(1);

        if (!kill) begin
            case (state_q)
                IDLE: if (start) begin
                    x_d   = '0;
                    y_d   = '0;
                    idx_d = '0;
                end
                HEADER: if (can_send) begin
                    wr_d  = 1'b1;
                    dat_d = idx_q[0] ? SYNC1 : SYNC0;
                    idx_d = idx_q + 2'd1;
                end
                LATCH: begin
                    word_d = read_q;
                    idx_d  = '0;
                end
                SEND: if (can_send) begin
                    wr_d  = 1'b1;
                    dat_d = word_q[{~idx_q, 3'b000} +: 8];
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (x_q < X_LAST) begin
                            x_d = x_q + 6'd1;
                        end else if (y_q < Y_LAST) begin
                            x_d = '0;
                            y_d = y_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_x   = x_q;
    assign read_y   = y_q;
    assign uart_wr  = wr_q;
    assign uart_dat = dat_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/frame_uart_sequencer.md
FRAME_UART_SEQUENCER -- requirements
Module: frame_uart_sequencer

Interface
REQ-001 The block SHALL have parameter COLS, default 40, meaning 32-bit words per buffer row (1..64).
REQ-002 The block SHALL have parameter ROWS, default 30, meaning rows per frame (1..32).
REQ-003 The block SHALL have parameter HOLDOFF_BITS, default 13, meaning the width of the idle-gap counter between UART bytes.
REQ-004 The block SHALL have parameter SYNC0, default 8'hFF, meaning the first header byte.
REQ-005 The block SHALL have parameter SYNC1, default 8'h00, meaning the second header byte.
REQ-006 The block SHALL have the port list below; there is one clock and reset is asynchronous, active-low.
- clk12  in  1  system clock, 12 MHz
- areset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to send one frame
- abort  in  1  one-cycle cancel request
- frame_done  in  1  one-cycle pulse, buffer holds a complete frame, already in the clk12 domain
- read_x  out  6  buffer column address
- read_y  out  5  buffer row address
- read_q  in  32  buffer word; valid 1 cycle after the address
- uart_busy  in  1  UART transmitting
- uart_wr  out  1  one-cycle byte strobe
- uart_dat  out  8  byte to transmit, valid while uart_wr=1
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes normally

Function
REQ-007 States SHALL be IDLE, WAIT_FRAME, HEADER, FETCH, LATCH, SEND, DONE.
REQ-008 IDLE: busy=0; start=1 SHALL clear read_x, read_y and the byte index, then go to WAIT_FRAME.
REQ-009 start in any state other than IDLE SHALL be ignored.
REQ-010 WAIT_FRAME: a frame_done pulse SHALL move the block to HEADER; frame_done in other states SHALL be ignored.
REQ-011 HEADER: the block SHALL send SYNC0 then SYNC1 under the send rule of REQ-015, then go to FETCH.
REQ-012 FETCH: read_x/read_y SHALL be stable for exactly one cycle, then the block goes to LATCH.
REQ-013 LATCH: read_q SHALL be registered into a word register, the byte index set to 0, then the block goes to SEND.
REQ-014 SEND: bytes SHALL go out MSB first: [31:24], [23:16], [15:8], [7:0].
REQ-015 Send rule: a byte SHALL be issued only when the holdoff counter is all-ones, uart_busy=0 and uart_wr=0.
- Issuing a byte asserts uart_wr for exactly 1 cycle, with uart_dat held for that cycle.
REQ-016 Holdoff counter (HOLDOFF_BITS wide):
- cleared in any cycle with uart_busy=1 or uart_wr=1;
- otherwise increments;
- saturates at all-ones, never wraps.
REQ-017 After byte index 3 is issued:
- if read_x<COLS-1: read_x+1, go to FETCH;
- else if read_y<ROWS-1: read_x=0, read_y+1, go to FETCH;
- else: go to DONE.
REQ-018 DONE: done=1 for one cycle, then IDLE; read_x and read_y SHALL hold their final values.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Total bytes per transfer SHALL be 2+4*COLS*ROWS; default 4802.
REQ-021 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with done=0.
- A byte strobe in the same cycle as abort SHALL be suppressed.
REQ-022 abort and start in the same cycle in IDLE: start SHALL win.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 areset_n=0 SHALL immediately force state=IDLE and set:
- read_x=0, read_y=0, uart_wr=0, uart_dat=0, busy=0, done=0;
- holdoff counter=0, word register=0, byte index=0.
REQ-025 The block SHALL resume on the first clk12 edge after areset_n deasserts; reset mid-transfer SHALL drop the transfer silently.

Verification (COLS=2, ROWS=2, HOLDOFF_BITS=2, UART model busy for 10 cycles, starting the cycle after uart_wr)
REQ-026 Full transfer: start, frame_done, buffer word = {y,x,y,x} bytes -> 18 bytes FF,00,00,00,00,00,00,01,00,01,01,00,01,00,01,01,01,01; then one done pulse; busy=0.
REQ-027 Byte spacing: consecutive uart_wr pulses SHALL be ≥ 10+3+1 cycles apart; uart_wr never asserts while uart_busy=1.
REQ-028 start without frame_done for 1000 cycles -> uart_wr stays 0, busy=1; a later frame_done starts the header.
REQ-029 abort after the 5th byte -> no further uart_wr, done stays 0, busy=0 next cycle; a new start plus frame_done restarts from the FF header.
REQ-030 areset_n pulsed low mid-SEND -> all outputs 0 asynchronously; no uart_wr until a new start.
REQ-031 start re-asserted during SEND and frame_done pulses during SEND -> exactly 18 bytes and a single done.
